// File: rtl/cc_transition_sequencer.sv
// Screen-code sequencer: level splash for a timed dwell, then play, then trophy on win.
// Drives the 3-bit pattern-table code and a reload pulse for the register bank.
module cc_transition_sequencer #(
  parameter int unsigned CLK_DIV     = 50000000,
  parameter int unsigned DWELL_TICKS = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET_InLow,
  input  logic       START_InHigh,
  input  logic [2:0] LEVEL_InBUS,
  input  logic       WIN_InHigh,
  input  logic       ABORT_InHigh,
  output logic [2:0] TRANSITION_OutBUS,
  output logic       LOAD_OutHigh,
  output logic       PLAY_OutHigh,
  output logic       BUSY_OutHigh
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_WIN  = 2'd3;

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  localparam logic [2:0] CODE_IDLE   = 3'b000;
  localparam logic [2:0] CODE_TROPHY = 3'b101;

  logic [1:0]    state_q, state_d;
  logic [2:0]    level_q, level_d;
  logic [PW-1:0] pre_q,   pre_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    code_q,  code_d;
  logic          load_q,  load_d;
  logic          play_q,  play_d;
  logic          busy_q,  busy_d;

  logic start_ok;
  logic tick;

  assign start_ok = START_InHigh && (LEVEL_InBUS != 3'd0) && (LEVEL_InBUS <= 3'd4);
  assign tick     = (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    pre_d   = '0;
    dwell_d = '0;

    // Counters default to 0, so every exit from SHOW and every (re)entry clears them.
    if (ABORT_InHigh) begin
      state_d = ST_IDLE;
    end else if (start_ok && (state_q != ST_PLAY)) begin
      state_d = ST_SHOW;
      level_d = LEVEL_InBUS;
    end else if (WIN_InHigh && (state_q == ST_PLAY)) begin
      state_d = ST_WIN;
    end else if (state_q == ST_SHOW) begin
      if (tick) begin
        if (dwell_q == DWELL_LAST) begin
          state_d = ST_PLAY;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end else begin
        pre_d   = pre_q + 1'b1;
        dwell_d = dwell_q;
      end
    end

    case (state_d)
      ST_SHOW: code_d = level_d;
      ST_WIN:  code_d = CODE_TROPHY;
      default: code_d = CODE_IDLE;
    endcase

    load_d = (code_d != code_q);
    busy_d = (state_d == ST_SHOW);
    play_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      pre_q   <= '0;
      dwell_q <= '0;
      code_q  <= CODE_IDLE;
      load_q  <= 1'b0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pre_q   <= pre_d;
      dwell_q <= dwell_d;
      code_q  <= code_d;
      load_q  <= load_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
    end
  end

  assign TRANSITION_OutBUS = code_q;
  assign LOAD_OutHigh      = load_q;
  assign PLAY_OutHigh      = play_q;
  assign BUSY_OutHigh      = busy_q;

endmodule

// File: tb/tb_cc_transition_sequencer.sv
// Bench for cc_transition_sequencer: directed scenarios plus random pulses,
// all compared each cycle against a mode/age reference model.
module tb_cc_transition_sequencer;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned DWELL_TICKS = 3;
  localparam int unsigned SHOW_LEN    = CLK_DIV * DWELL_TICKS;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] level;
  logic       win;
  logic       abort;
  logic [2:0] code;
  logic       load;
  logic       play;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_SHOW, M_PLAY, M_WIN} mode_t;
  mode_t       m_mode;
  int unsigned m_age;
  logic [2:0]  m_level;
  logic [2:0]  m_code;
  logic        m_load;

  cc_transition_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .DWELL_TICKS(DWELL_TICKS)
  ) dut (
    .CLOCK_50         (clk),
    .RESET_InLow      (rst_n),
    .START_InHigh     (start),
    .LEVEL_InBUS      (level),
    .WIN_InHigh       (win),
    .ABORT_InHigh     (abort),
    .TRANSITION_OutBUS(code),
    .LOAD_OutHigh     (load),
    .PLAY_OutHigh     (play),
    .BUSY_OutHigh     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] mode_code(input mode_t md, input logic [2:0] lv);
    case (md)
      M_SHOW:  return lv;
      M_WIN:   return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_age   = 0;
    m_level = 3'd0;
    m_code  = 3'b000;
    m_load  = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic [2:0] l, input logic w, input logic a);
    logic [2:0] prev;
    prev = m_code;
    if (a) begin
      m_mode = M_IDLE;
    end else if (s && l >= 3'd1 && l <= 3'd4 && m_mode != M_PLAY) begin
      m_mode  = M_SHOW;
      m_level = l;
      m_age   = 0;
    end else if (w && m_mode == M_PLAY) begin
      m_mode = M_WIN;
    end else if (m_mode == M_SHOW) begin
      m_age++;
      if (m_age == SHOW_LEN) m_mode = M_PLAY;
    end
    m_code = mode_code(m_mode, m_level);
    m_load = (m_code != prev);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_code"}, 32'(code), 32'(m_code));
    check({tag, "_load"}, 32'(load), 32'(m_load));
    check({tag, "_play"}, 32'(play), 32'(m_mode == M_PLAY));
    check({tag, "_busy"}, 32'(busy), 32'(m_mode == M_SHOW));
  endtask

  task automatic cycle(input logic s, input logic [2:0] l, input logic w, input logic a,
                       input string tag);
    start = s;
    level = l;
    win   = w;
    abort = a;
    @(posedge clk);
    model_step(s, l, w, a);
    #1;
    check_outputs(tag);
    start = 1'b0;
    level = 3'd0;
    win   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_play(input string tag, input int unsigned expect_n);
    int unsigned n;
    n = 0;
    while (!play && n < 3 * SHOW_LEN) begin
      cycle(1'b0, 3'd0, 1'b0, 1'b0, tag);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(expect_n));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    level = 3'd0;
    win   = 1'b0;
    abort = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: level 2 splash, then play after the full dwell
    cycle(1'b1, 3'd2, 1'b0, 1'b0, "t1_start");
    check("t1_code", 32'(code), 32'h2);
    check("t1_load", 32'(load), 32'h1);
    wait_play("t1", SHOW_LEN);
    check("t1_play_load", 32'(load), 32'h1);

    // 2: win shows trophy, then start level 4 from the trophy
    cycle(1'b0, 3'd0, 1'b1, 1'b0, "t2_win");
    check("t2_trophy", 32'(code), 32'h5);
    cycle(1'b1, 3'd4, 1'b0, 1'b0, "t2_start4");
    check("t2_code4", 32'(code), 32'h4);

    // 3: invalid levels ignored in idle
    cycle(1'b0, 3'd0, 1'b0, 1'b1, "t3_abort");
    cycle(1'b1, 3'd0, 1'b0, 1'b0, "t3_lvl0");
    cycle(1'b1, 3'd5, 1'b0, 1'b0, "t3_lvl5");
    check("t3_load", 32'(load), 32'h0);
    cycle(1'b0, 3'd0, 1'b0, 1'b1, "t3_abort_idle");

    // 4: restart mid-splash with a different level
    cycle(1'b1, 3'd1, 1'b0, 1'b0, "t4_start1");
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 1'b0, 1'b0, "t4_show");
    cycle(1'b1, 3'd3, 1'b0, 1'b0, "t4_start3");
    check("t4_code3", 32'(code), 32'h3);
    check("t4_load", 32'(load), 32'h1);
    wait_play("t4", SHOW_LEN);

    // 5: abort wins over a simultaneous start
    cycle(1'b1, 3'd0, 1'b0, 1'b1, "t5_abort");
    cycle(1'b1, 3'd2, 1'b0, 1'b0, "t5_start");
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b0, 1'b0, "t5_show");
    cycle(1'b1, 3'd3, 1'b0, 1'b1, "t5_both");
    check("t5_idle_load", 32'(load), 32'h1);

    // 6: asynchronous reset mid-splash, then a stray win
    cycle(1'b1, 3'd1, 1'b0, 1'b0, "t6_start");
    cycle(1'b0, 3'd0, 1'b0, 1'b0, "t6_show");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_async");
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 3'd0, 1'b1, 1'b0, "t6_win_ignored");

    // Random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 59) == 0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
